// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FPU between NREQ engines.
// A grant in cycle t issues to the FPU in t+1; the owner index rides a
// LAT-deep tag pipeline so the result strobe returns to the right engine
// in t+1+LAT.
// Optional feature: define FPU_ARB_LOCK_EN to let the last owner keep the
// grant while it holds both req_i and lock_i (burst lock).
module fpu_arbiter #(
  parameter int NREQ   = 4,
  parameter int MODE_W = 4,
  parameter int DW     = 256,
  parameter int LAT    = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ-1:0]        lock_i,
  input  logic [NREQ*MODE_W-1:0] mode_i,
  input  logic [NREQ*DW-1:0]     data_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic                   fpu_vld_o,
  output logic [MODE_W-1:0]      fpu_mode_o,
  output logic [DW-1:0]          fpu_d_o,
  input  logic [DW-1:0]          fpu_res_i,
  output logic [NREQ-1:0]        rsp_vld_o,
  output logic [DW-1:0]          rsp_data_o,
  output logic                   busy_o
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  cand_idx;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              locked;
  logic [MODE_W-1:0] sel_mode;
  logic [DW-1:0]     sel_data;

  logic              vld_p0;
  logic [PTR_W-1:0]  idx_p0;
  logic [MODE_W-1:0] mode_p0;
  logic [DW-1:0]     data_p0;

  logic [LAT-1:0]    tag_vld_p1;
  logic [PTR_W-1:0]  tag_idx_p1 [LAT];

`ifdef FPU_ARB_LOCK_EN
  logic              owner_vld;
  logic [PTR_W-1:0]  owner_idx;
`else
  // lock_i has no function in this build; collapse it onto a dead net.
  logic              unused_lock;
  assign unused_lock = ^lock_i;
`endif

  // Pick the winner: locked owner first (if enabled), else first request at or above rr_ptr.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    locked   = 1'b0;
    cand_idx = '0;
`ifdef FPU_ARB_LOCK_EN
    if (owner_vld && req_i[owner_idx] && lock_i[owner_idx]) begin
      gnt_any = 1'b1;
      gnt_idx = owner_idx;
      locked  = 1'b1;
    end
`endif
    for (int i = 0; i < NREQ; i++) begin
      cand_idx = PTR_W'((int'(rr_ptr) + i) % NREQ);
      if (!gnt_any && req_i[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    // No grants may escape while reset is held.
    if (!rst_n) begin
      gnt_any = 1'b0;
      locked  = 1'b0;
    end
  end

  // One-hot grant vector and the winner's operand slices.
  always_comb begin
    gnt_o    = '0;
    sel_mode = '0;
    sel_data = '0;
    if (gnt_any) gnt_o[gnt_idx] = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == PTR_W'(k)) begin
        sel_mode = mode_i[k*MODE_W +: MODE_W];
        sel_data = data_i[k*DW +: DW];
      end
    end
  end

  // Advance the round-robin pointer past each unlocked winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_any && !locked) begin
      rr_ptr <= (gnt_idx == PTR_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

`ifdef FPU_ARB_LOCK_EN
  // Remember the most recent owner for burst locking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_vld <= 1'b0;
      owner_idx <= '0;
    end else if (gnt_any) begin
      owner_vld <= 1'b1;
      owner_idx <= gnt_idx;
    end
  end
`endif

  // ---- stage p0: issue register towards the FPU ----
  // Register the granted operation; operands hold when nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      idx_p0  <= '0;
      mode_p0 <= '0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= gnt_any;
      if (gnt_any) begin
        idx_p0  <= gnt_idx;
        mode_p0 <= sel_mode;
        data_p0 <= sel_data;
      end
    end
  end

  assign fpu_vld_o  = vld_p0;
  assign fpu_mode_o = mode_p0;
  assign fpu_d_o    = data_p0;

  // ---- stage p1: LAT-deep ownership tags matching the FPU latency ----
  // Shift {valid, owner} one slot per cycle; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_p1 <= '0;
      for (int i = 0; i < LAT; i++) tag_idx_p1[i] <= '0;
    end else begin
      tag_vld_p1[0] <= vld_p0;
      tag_idx_p1[0] <= idx_p0;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_p1[i] <= tag_vld_p1[i-1];
        tag_idx_p1[i] <= tag_idx_p1[i-1];
      end
    end
  end

  // Route the returning result strobe to its owner.
  always_comb begin
    rsp_vld_o = '0;
    if (tag_vld_p1[LAT-1]) rsp_vld_o[tag_idx_p1[LAT-1]] = 1'b1;
  end

  assign rsp_data_o = fpu_res_i;
  assign busy_o     = vld_p0 | (|tag_vld_p1);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: directed scenarios plus randomized traffic, with a
// queue-based reference model and a negedge monitor acting as scoreboard.
module tb_fpu_arbiter;

  localparam int NREQ   = 4;
  localparam int MODE_W = 4;
  localparam int DW     = 256;
  localparam int LAT    = 6;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_i;
  logic [NREQ-1:0]        lock_i;
  logic [NREQ*MODE_W-1:0] mode_i;
  logic [NREQ*DW-1:0]     data_i;
  logic [NREQ-1:0]        gnt_o;
  logic                   fpu_vld_o;
  logic [MODE_W-1:0]      fpu_mode_o;
  logic [DW-1:0]          fpu_d_o;
  logic [DW-1:0]          fpu_res_i;
  logic [NREQ-1:0]        rsp_vld_o;
  logic [DW-1:0]          rsp_data_o;
  logic                   busy_o;

  fpu_arbiter #(.NREQ(NREQ), .MODE_W(MODE_W), .DW(DW), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .lock_i     (lock_i),
    .mode_i     (mode_i),
    .data_i     (data_i),
    .gnt_o      (gnt_o),
    .fpu_vld_o  (fpu_vld_o),
    .fpu_mode_o (fpu_mode_o),
    .fpu_d_o    (fpu_d_o),
    .fpu_res_i  (fpu_res_i),
    .rsp_vld_o  (rsp_vld_o),
    .rsp_data_o (rsp_data_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [NREQ-1:0] gnt; } gnt_t;
  typedef struct { int cyc; logic [MODE_W-1:0] mode; logic [DW-1:0] data; } iss_t;
  typedef struct { int cyc; int idx; } rsp_t;

  gnt_t gnt_q [$];
  iss_t iss_q [$];
  rsp_t rsp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: next engine to favour, and last owner for locking.
  int m_ptr       = 0;
  int m_owner     = 0;
  bit m_owner_vld = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Winner per the arbitration rules, or -1 when nobody requests.
  function automatic int model_winner(input logic [NREQ-1:0] req, input logic [NREQ-1:0] lock,
                                      output bit was_locked);
    was_locked = 1'b0;
`ifdef FPU_ARB_LOCK_EN
    if (m_owner_vld && req[m_owner] && lock[m_owner]) begin
      was_locked = 1'b1;
      return m_owner;
    end
`endif
    for (int off = 0; off < NREQ; off++) begin
      if (req[(m_ptr + off) % NREQ]) return (m_ptr + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic randomize_operands();
    for (int b = 0; b < NREQ*MODE_W; b++) mode_i[b] = 1'($urandom);
    for (int b = 0; b < NREQ*DW/32; b++) data_i[b*32 +: 32] = $urandom;
    for (int b = 0; b < DW/32; b++) fpu_res_i[b*32 +: 32] = $urandom;
  endtask

  // Drive one cycle of requests and record what the design must do with them.
  task automatic step(input logic [NREQ-1:0] req, input logic [NREQ-1:0] lock);
    int   k;
    bit   lk;
    gnt_t g;
    iss_t s;
    rsp_t r;
    @(posedge clk);
    #1;
    req_i  = req;
    lock_i = lock;
    randomize_operands();
    k = model_winner(req, lock, lk);
    g.cyc = cyc;
    g.gnt = '0;
    if (k >= 0) begin
      g.gnt[k] = 1'b1;
      s.cyc  = cyc + 1;
      s.mode = mode_i[k*MODE_W +: MODE_W];
      s.data = data_i[k*DW +: DW];
      iss_q.push_back(s);
      r.cyc = cyc + 1 + LAT;
      r.idx = k;
      rsp_q.push_back(r);
      if (!lk) m_ptr = (k + 1) % NREQ;
      m_owner     = k;
      m_owner_vld = 1'b1;
    end
    gnt_q.push_back(g);
  endtask

  task automatic reset_pulse(input int hold);
    gnt_t g;
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    req_i  = '0;
    lock_i = '0;
    iss_q.delete();
    rsp_q.delete();
    m_ptr       = 0;
    m_owner     = 0;
    m_owner_vld = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    g.cyc = cyc;
    g.gnt = '0;
    gnt_q.push_back(g);
  endtask

  // Scoreboard monitor: compare DUT outputs against queued expectations each cycle.
  logic [MODE_W-1:0] last_mode = '0;
  logic [DW-1:0]     last_data = '0;

  initial begin
    gnt_t g;
    iss_t s;
    rsp_t r;
    logic [NREQ-1:0] exp_rsp;
    bit exp_busy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_gnt", DW'(gnt_o), '0);
        check("rst_fpu_vld", DW'(fpu_vld_o), '0);
        check("rst_fpu_mode", DW'(fpu_mode_o), '0);
        check("rst_fpu_d", fpu_d_o, '0);
        check("rst_rsp_vld", DW'(rsp_vld_o), '0);
        check("rst_busy", DW'(busy_o), '0);
        last_mode = '0;
        last_data = '0;
      end else begin
        if (gnt_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL gnt_queue at cycle %0d: got empty queue, expected an entry", cyc);
        end else begin
          g = gnt_q.pop_front();
          check("gnt", DW'(gnt_o), DW'(g.gnt));
        end

        if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
          s = iss_q.pop_front();
          check("fpu_vld", DW'(fpu_vld_o), DW'(1'b1));
          check("fpu_mode", DW'(fpu_mode_o), DW'(s.mode));
          check("fpu_d", fpu_d_o, s.data);
          last_mode = s.mode;
          last_data = s.data;
        end else begin
          check("fpu_vld_idle", DW'(fpu_vld_o), '0);
          check("fpu_mode_hold", DW'(fpu_mode_o), DW'(last_mode));
          check("fpu_d_hold", fpu_d_o, last_data);
        end

        exp_busy = 1'b0;
        foreach (rsp_q[i]) if (rsp_q[i].cyc - LAT <= cyc) exp_busy = 1'b1;
        check("busy", DW'(busy_o), DW'(exp_busy));

        exp_rsp = '0;
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
          r = rsp_q.pop_front();
          exp_rsp[r.idx] = 1'b1;
          check("rsp_data", rsp_data_o, fpu_res_i);
        end
        check("rsp_vld", DW'(rsp_vld_o), DW'(exp_rsp));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_i     = '0;
    lock_i    = '0;
    mode_i    = '0;
    data_i    = '0;
    fpu_res_i = '0;
    reset_pulse(3);

    // All four requesting from reset: strict rotation, responses 7 cycles later.
    repeat (8) step(4'b1111, 4'b0000);
    repeat (10) step(4'b0000, 4'b0000);

    // Single request from engine 2, leaves the pointer at 3.
    step(4'b0100, 4'b0000);
    repeat (9) step(4'b0000, 4'b0000);

    // Wrap-around between engines 3 and 0.
    repeat (3) step(4'b1001, 4'b0000);
    repeat (8) step(4'b0000, 4'b0000);

    // Burst lock on engine 0, then release (plain rotation when locking is off).
    repeat (4) step(4'b0011, 4'b0001);
    step(4'b0011, 4'b0000);
    repeat (8) step(4'b0000, 4'b0000);

    // Three back-to-back issues, then reset with all of them in flight.
    repeat (3) step(4'b1111, 4'b0000);
    step(4'b0000, 4'b0000);
    reset_pulse(1);
    repeat (8) step(4'b0000, 4'b0000);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset_pulse($urandom_range(1, 3));
      end else begin
        step(NREQ'($urandom), ($urandom_range(0, 1) == 1) ? NREQ'($urandom) : '0);
      end
    end

    repeat (LAT + 4) step(4'b0000, 4'b0000);
    @(posedge clk);
    #2;
    check("iss_q_drained", DW'(iss_q.size()), '0);
    check("rsp_q_drained", DW'(rsp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
